// File: rtl/sat_acc_seq.sv
// Saturating signed 12-bit accumulator over a run of len terms.
// Handshakes: start/start_ready, in_valid/in_ready, res_valid/res_ready.
module sat_acc_seq #(
  parameter int LEN_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             start_ready,
  input  logic             in_valid,
  input  logic [11:0]      in_data,
  output logic             in_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [11:0]      res,
  output logic             sat
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] CNT_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] CNT_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

  // Result bit 12 flags a clamped add; bits 11:0 are the (possibly clamped) sum.
  function automatic logic [12:0] f_satadd(input logic [11:0] a, input logic [11:0] b);
    logic [11:0] sum;
    sum = a + b;
    if (!a[11] && !b[11] && sum[11]) begin
      f_satadd = {1'b1, 12'h7FF};
    end else if (a[11] && b[11] && !sum[11]) begin
      f_satadd = {1'b1, 12'h800};
    end else begin
      f_satadd = {1'b0, sum};
    end
  endfunction

  state_t           r_state;
  logic [11:0]      r_acc;
  logic             r_sat;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] r_len;
  logic             r_start_ready;
  logic             r_in_ready;
  logic             r_res_valid;

  logic [12:0]      w_add;
  logic [LEN_W-1:0] w_cnt_nxt;
  logic             w_start_acc;
  logic             w_beat;

  assign w_add       = f_satadd(r_acc, in_data);
  assign w_cnt_nxt   = r_cnt + CNT_ONE;
  assign w_start_acc = start && (r_state == S_IDLE);
  assign w_beat      = in_valid && (r_state == S_ACC);

  // Run control FSM; handshake outputs are registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_acc         <= 12'h000;
      r_sat         <= 1'b0;
      r_cnt         <= CNT_ZERO;
      r_len         <= CNT_ZERO;
      r_start_ready <= 1'b1;
      r_in_ready    <= 1'b0;
      r_res_valid   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_acc) begin
            r_len         <= len;
            r_acc         <= 12'h000;
            r_sat         <= 1'b0;
            r_cnt         <= CNT_ZERO;
            r_start_ready <= 1'b0;
            if (len != CNT_ZERO) begin
              r_state    <= S_ACC;
              r_in_ready <= 1'b1;
            end else begin
              r_state     <= S_DONE;
              r_res_valid <= 1'b1;
            end
          end
        end
        S_ACC: begin
          if (w_beat) begin
            r_acc <= w_add[11:0];
            r_sat <= r_sat | w_add[12];
            r_cnt <= w_cnt_nxt;
            // Counter stays below len, so the increment never wraps.
            if (w_cnt_nxt == r_len) begin
              r_state     <= S_DONE;
              r_in_ready  <= 1'b0;
              r_res_valid <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (res_ready) begin
            r_state       <= S_IDLE;
            r_res_valid   <= 1'b0;
            r_start_ready <= 1'b1;
          end
        end
        default: begin
          r_state       <= S_IDLE;
          r_start_ready <= 1'b1;
          r_in_ready    <= 1'b0;
          r_res_valid   <= 1'b0;
        end
      endcase
    end
  end

  assign start_ready = r_start_ready;
  assign in_ready    = r_in_ready;
  assign res_valid   = r_res_valid;
  assign res         = r_acc;
  assign sat         = r_sat;

endmodule

// File: tb/tb_sat_acc_seq.sv
// Randomized self-checking bench for sat_acc_seq against an integer
// clamp-to-range reference model.
module tb_sat_acc_seq;

  localparam int LEN_W = 5;

  logic             clk;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             start_ready;
  logic             in_valid;
  logic [11:0]      in_data;
  logic             in_ready;
  logic             res_valid;
  logic             res_ready;
  logic [11:0]      res;
  logic             sat;

  int n_checks;
  int n_fails;
  logic [11:0] terms [0:31];

  sat_acc_seq #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .start_ready(start_ready),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res(res), .sat(sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer sum clamped to the 12-bit signed range after each term.
  task automatic model(input int n, output logic [11:0] exp_res, output logic exp_sat);
    int acc;
    acc = 0;
    exp_sat = 1'b0;
    for (int i = 0; i < n; i++) begin
      acc = acc + int'($signed(terms[i]));
      if (acc > 2047) begin
        acc = 2047;
        exp_sat = 1'b1;
      end else if (acc < -2048) begin
        acc = -2048;
        exp_sat = 1'b1;
      end
    end
    exp_res = 12'(acc);
  endtask

  // Feed beats with random gaps until n beats transferred; returns beats sent.
  task automatic feed(input int n, input int gap_pct, output int sent);
    int cyc;
    logic xfer;
    sent = 0;
    cyc = 0;
    while (sent < n && cyc < 2000) begin
      in_valid = ($urandom_range(0, 99) >= gap_pct);
      in_data  = in_valid ? terms[sent] : 12'($urandom);
      xfer = in_valid && in_ready;
      if (sent > 0) check_eq("busy_res_valid", 32'(res_valid), 32'd0);
      tick();
      if (xfer) sent++;
      cyc++;
    end
    in_valid = 1'b0;
    if (cyc >= 2000) check_eq("beat_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_run(input int n, input int gap_pct, input int hold);
    logic [11:0] exp_res;
    logic        exp_sat;
    int          sent;
    model(n, exp_res, exp_sat);
    check_eq("idle_start_ready", 32'(start_ready), 32'd1);
    start = 1'b1;
    len   = LEN_W'(n);
    tick();
    start = 1'b0;
    len   = LEN_W'($urandom);
    check_eq("post_start_ready", 32'(start_ready), 32'd0);
    if (n > 0) begin
      check_eq("acc_in_ready", 32'(in_ready), 32'd1);
      check_eq("acc_res_valid", 32'(res_valid), 32'd0);
      feed(n, gap_pct, sent);
    end
    check_eq("done_res_valid", 32'(res_valid), 32'd1);
    check_eq("done_in_ready", 32'(in_ready), 32'd0);
    check_eq("done_res", 32'(res), 32'(exp_res));
    check_eq("done_sat", 32'(sat), 32'(exp_sat));
    for (int h = 0; h < hold; h++) begin
      start    = $urandom_range(0, 1) == 1;
      in_valid = $urandom_range(0, 1) == 1;
      in_data  = 12'($urandom);
      len      = LEN_W'($urandom);
      tick();
      check_eq("hold_res", 32'(res), 32'(exp_res));
      check_eq("hold_sat", 32'(sat), 32'(exp_sat));
      check_eq("hold_res_valid", 32'(res_valid), 32'd1);
      check_eq("hold_in_ready", 32'(in_ready), 32'd0);
      check_eq("hold_start_ready", 32'(start_ready), 32'd0);
    end
    // Start coincident with the result handshake must be ignored.
    start     = 1'b1;
    in_valid  = 1'b0;
    res_ready = 1'b1;
    len       = 5'd3;
    tick();
    start     = 1'b0;
    res_ready = 1'b0;
    check_eq("ack_res_valid", 32'(res_valid), 32'd0);
    check_eq("ack_start_ready", 32'(start_ready), 32'd1);
    check_eq("ack_in_ready", 32'(in_ready), 32'd0);
    check_eq("idle_res", 32'(res), 32'(exp_res));
    check_eq("idle_sat", 32'(sat), 32'(exp_sat));
    tick();
    check_eq("idle2_start_ready", 32'(start_ready), 32'd1);
    check_eq("idle2_res_valid", 32'(res_valid), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_start_ready"}, 32'(start_ready), 32'd1);
    check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check_eq({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check_eq({tag, "_res"}, 32'(res), 32'd0);
    check_eq({tag, "_sat"}, 32'(sat), 32'd0);
  endtask

  initial begin
    int sent;
    n_checks  = 0;
    n_fails   = 0;
    rst       = 1'b1;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    in_data   = 12'h000;
    res_ready = 1'b0;
    #12;
    check_reset_vals("reset");
    rst = 1'b0;
    tick();

    terms[0] = 12'd100; terms[1] = 12'hFCE; terms[2] = 12'd25;
    do_run(3, 0, 0);
    terms[0] = 12'h7F0; terms[1] = 12'h020;
    do_run(2, 0, 1);
    terms[0] = 12'h800; terms[1] = 12'hFFF;
    do_run(2, 0, 1);
    terms[0] = 12'h7F0; terms[1] = 12'h020; terms[2] = 12'hFFF;
    do_run(3, 0, 0);
    do_run(0, 0, 0);
    terms[0] = 12'd7; terms[1] = 12'hFF9; terms[2] = 12'h400; terms[3] = 12'h3FF;
    do_run(4, 40, 5);
    for (int i = 0; i < 31; i++) terms[i] = 12'd100;
    do_run(31, 20, 0);

    // Abandon a run mid-way with an asynchronous reset pulse.
    for (int i = 0; i < 4; i++) terms[i] = 12'h600;
    start = 1'b1;
    len   = 5'd4;
    tick();
    start = 1'b0;
    feed(2, 0, sent);
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("midrst");
    #3;
    rst = 1'b0;
    tick();
    check_reset_vals("postrst");
    terms[0] = 12'd5;
    do_run(1, 0, 0);

    for (int r = 0; r < 40; r++) begin
      int n;
      n = $urandom_range(0, 31);
      for (int i = 0; i < 32; i++) begin
        if (r % 2 == 0) terms[i] = 12'($urandom);
        else            terms[i] = 12'($signed(12'($urandom_range(0, 400))) - 12'sd200);
      end
      do_run(n, $urandom_range(0, 60), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
